mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter that shares the CPU's single memory bus between instruction fetch (IF) and data access (D). It runs a round-robin grant FSM and latches the winning request's address, write flag and write data into internal holding registers. It drives one memory transaction at a time, captures read data into per-requester output registers, and returns a one-cycle acknowledge. A watchdog aborts transactions the memory never completes.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT, 16, max grant cycles waiting for mem_ready before abort (≥2)

- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-low reset (sampled on rising clk edge when 0)
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req
- if_rdata  out  DATA_WIDTH  registered fetch read data
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_rdata  out  DATA_WIDTH  registered data read value
- d_ack  out  1  one-cycle data completion pulse
- bus_err  out  1  pulses with the ack of a timed-out transaction
- mem_req  out  1  memory transaction active
- mem_we  out  1  registered write flag
- mem_addr  out  ADDR_WIDTH  registered address
- mem_wdata  out  DATA_WIDTH  registered write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid when mem_ready
- mem_ready  in  1  memory completes the current transaction this cycle

## Operation
- **States:** IDLE, GNT_IF, GNT_D, DONE.
- **IDLE:**
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant the requester not in last_grant, then update last_grant.
  - On grant, latch address, we (IF always 0) and wdata into the mem_* registers.
  - Clear the watchdog counter.
  - Go to GNT_IF or GNT_D.
- **GNT_x:**
  - mem_req = 1.
  - The counter increments each cycle mem_ready = 0.
  - mem_ready = 1:
    - Read: capture mem_rdata into x's rdata register.
    - Go to DONE with ack_x set.
  - Counter reaches TIMEOUT−1 with mem_ready = 0:
    - Go to DONE with ack_x and bus_err set.
    - rdata is not updated.
- **DONE:**
  - x_ack = 1 for exactly this cycle; bus_err = 1 if aborted.
  - mem_req = 0.
  - No arbitration in this cycle, so the completing requester can drop or renew req.
  - Next state is IDLE.
- **Writes** never modify d_rdata.
- **Holding registers:** mem_addr, mem_we and mem_wdata keep their last values outside grant states. Only mem_req qualifies the bus.
- **Requester changes:** a req that deasserts before ack is a protocol violation. The arbiter completes the transaction anyway.

## Timing
- **Reset** (reset = 0 at a clk edge):
  - state = IDLE.
  - mem_req, mem_we, if_ack, d_ack, bus_err = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - Counter = 0; last_grant = D, so IF wins the first tie.
  - Reset mid-transaction aborts it without ack. mem_req is 0 the cycle after reset is sampled.
- **Latency:**
  - req sampled high in IDLE at edge N.
  - mem_req high from cycle N+1.
  - mem_ready sampled at edge M ≥ N+1.
  - ack high during cycle M+1.
  - IDLE at M+2; minimum req-to-ack is 2 cycles.
- **Back-to-back:** at most one transaction per 3 cycles (IDLE, GNT, DONE).
- **Timeout:** ack/bus_err are asserted TIMEOUT cycles after the first GNT cycle.
- **Simultaneous events:**
  - mem_ready on the same cycle the counter reaches TIMEOUT−1 is a normal completion with bus_err = 0.
  - A req arriving during GNT or DONE waits for IDLE.

## Test plan
- **Reset values:** hold reset = 0 with if_req = d_req = 1 → all outputs 0 and no mem_req. Release reset → IF granted first, mem_addr = if_addr.
- **Single read:** IF read addr 0x100, mem_ready one cycle after mem_req with mem_rdata = 0xDEADBEEF → if_rdata = 0xDEADBEEF and if_ack pulses exactly one cycle, 2 cycles after the req edge.
- **Round-robin:** both reqs held continuously, mem_ready immediate → grants alternate IF, D, IF, D. Each ack comes 3 cycles after the previous one.
- **Data write:** d_we = 1, addr 0x200, wdata 0x55AA → mem_we = 1, mem_wdata = 0x55AA, d_ack pulses and d_rdata is unchanged.
- **Timeout:** TIMEOUT = 4, mem_ready held 0 → d_ack and bus_err pulse together 4 cycles after the first GNT cycle. d_rdata is unchanged and the FSM returns to IDLE.
- **Reset mid-grant:** reset = 0 during GNT_D → no d_ack; mem_req = 0 next cycle; after release, last_grant = D so IF wins the next tie.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and data access,
// with registered bus outputs, per-requester read-data registers and a grant watchdog.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic LG_IF = 1'b0;
  localparam logic LG_D  = 1'b1;

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, DONE} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic                  bus_err_q, bus_err_d;
  logic                  grant_if;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= LG_D;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    bus_err_d    = 1'b0;
    grant_if     = if_req && (!d_req || (last_grant_q == LG_D));

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (if_req || d_req) begin
          mem_req_d = 1'b1;
          if (grant_if) begin
            state_d      = GNT_IF;
            last_grant_d = LG_IF;
            mem_addr_d   = if_addr;
            mem_we_d     = 1'b0;
          end else begin
            state_d      = GNT_D;
            last_grant_d = LG_D;
            mem_addr_d   = d_addr;
            mem_we_d     = d_we;
            mem_wdata_d  = d_wdata;
          end
        end
      end
      GNT_IF, GNT_D: begin
        // Completion beats the watchdog when both land on the same cycle
        if (mem_ready) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (state_q == GNT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == GNT_IF) if_ack_d = 1'b1;
          else                   d_ack_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: cycle table for reset, reads, round-robin and writes,
// then hand sequences for the watchdog, its boundary, and reset during a data grant.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we, mem_ready;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, mem_rdata, if_rdata, d_rdata, mem_wdata;
  logic          if_ack, d_ack, bus_err, mem_req, mem_we;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n, ifr, dr, we, rdy;
    logic [DW-1:0] wdata, rdata;
    logic          e_mreq, e_mwe;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwdata;
    logic          e_ifack, e_dack, e_err;
    logic [DW-1:0] e_ifrd, e_drd;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic rst_n, ifr, dr, we, rdy,
                              input logic [DW-1:0] wdata, rdata,
                              input logic e_mreq, e_mwe,
                              input logic [AW-1:0] e_maddr,
                              input logic [DW-1:0] e_mwdata,
                              input logic e_ifack, e_dack, e_err,
                              input logic [DW-1:0] e_ifrd, e_drd);
    vec_t v;
    v.rst_n = rst_n; v.ifr = ifr; v.dr = dr; v.we = we; v.rdy = rdy;
    v.wdata = wdata; v.rdata = rdata;
    v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.e_ifack = e_ifack; v.e_dack = e_dack; v.e_err = e_err;
    v.e_ifrd = e_ifrd; v.e_drd = e_drd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input int i, input vec_t v);
    chk("mem_req", i, 32'(mem_req), 32'(v.e_mreq));
    chk("mem_we", i, 32'(mem_we), 32'(v.e_mwe));
    chk("mem_addr", i, mem_addr, v.e_maddr);
    chk("mem_wdata", i, mem_wdata, v.e_mwdata);
    chk("if_ack", i, 32'(if_ack), 32'(v.e_ifack));
    chk("d_ack", i, 32'(d_ack), 32'(v.e_dack));
    chk("bus_err", i, 32'(bus_err), 32'(v.e_err));
    chk("if_rdata", i, if_rdata, v.e_ifrd);
    chk("d_rdata", i, d_rdata, v.e_drd);
  endtask

  initial begin
    // rst ifr dr we rdy wdata rdata | mreq mwe maddr mwdata ifack dack err ifrd drd
    vecs[0]  = mk(0,1,1,0,0, 32'h0,    32'h0,        0,0,32'h000,32'h0,    0,0,0,32'h0,        32'h0);
    vecs[1]  = mk(0,1,1,0,0, 32'h0,    32'h0,        0,0,32'h000,32'h0,    0,0,0,32'h0,        32'h0);
    vecs[2]  = mk(1,1,1,0,0, 32'h0,    32'h0,        1,0,32'h100,32'h0,    0,0,0,32'h0,        32'h0);
    vecs[3]  = mk(1,1,1,0,1, 32'h0,    32'hDEADBEEF, 0,0,32'h100,32'h0,    1,0,0,32'hDEADBEEF, 32'h0);
    vecs[4]  = mk(1,1,1,0,0, 32'h0,    32'h0,        0,0,32'h100,32'h0,    0,0,0,32'hDEADBEEF, 32'h0);
    vecs[5]  = mk(1,1,1,0,0, 32'h1111, 32'h0,        1,0,32'h200,32'h1111, 0,0,0,32'hDEADBEEF, 32'h0);
    vecs[6]  = mk(1,1,1,0,1, 32'h1111, 32'h12345678, 0,0,32'h200,32'h1111, 0,1,0,32'hDEADBEEF, 32'h12345678);
    vecs[7]  = mk(1,1,1,0,0, 32'h1111, 32'h0,        0,0,32'h200,32'h1111, 0,0,0,32'hDEADBEEF, 32'h12345678);
    vecs[8]  = mk(1,1,1,0,0, 32'h1111, 32'h0,        1,0,32'h100,32'h1111, 0,0,0,32'hDEADBEEF, 32'h12345678);
    vecs[9]  = mk(1,1,1,0,1, 32'h1111, 32'hCAFEF00D, 0,0,32'h100,32'h1111, 1,0,0,32'hCAFEF00D, 32'h12345678);
    vecs[10] = mk(1,0,1,1,0, 32'h55AA, 32'h0,        0,0,32'h100,32'h1111, 0,0,0,32'hCAFEF00D, 32'h12345678);
    vecs[11] = mk(1,0,1,1,0, 32'h55AA, 32'h0,        1,1,32'h200,32'h55AA, 0,0,0,32'hCAFEF00D, 32'h12345678);
    vecs[12] = mk(1,0,1,1,1, 32'h55AA, 32'hBADBAD00, 0,1,32'h200,32'h55AA, 0,1,0,32'hCAFEF00D, 32'h12345678);
    vecs[13] = mk(1,0,0,0,0, 32'h55AA, 32'h0,        0,1,32'h200,32'h55AA, 0,0,0,32'hCAFEF00D, 32'h12345678);

    if_addr = 32'h100;
    d_addr  = 32'h200;
    for (int i = 0; i < 14; i++) begin
      reset     = vecs[i].rst_n;
      if_req    = vecs[i].ifr;
      d_req     = vecs[i].dr;
      d_we      = vecs[i].we;
      mem_ready = vecs[i].rdy;
      d_wdata   = vecs[i].wdata;
      mem_rdata = vecs[i].rdata;
      step();
      chk_vec(i, vecs[i]);
    end

    // Watchdog: read that never completes aborts 4 cycles after the first grant cycle
    d_addr = 32'h300; d_we = 1'b0; d_req = 1'b1; mem_ready = 1'b0; mem_rdata = 32'hFFFF0000;
    step();
    chk("to_grant_req", 0, 32'(mem_req), 32'd1);
    chk("to_grant_addr", 0, mem_addr, 32'h300);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("to_wait_req", k, 32'(mem_req), 32'd1);
      chk("to_wait_ack", k, 32'(d_ack), 32'd0);
    end
    step();
    chk("to_ack", 0, 32'(d_ack), 32'd1);
    chk("to_err", 0, 32'(bus_err), 32'd1);
    chk("to_mreq", 0, 32'(mem_req), 32'd0);
    chk("to_rdata", 0, d_rdata, 32'h12345678);
    step();
    chk("to_ack_end", 0, 32'(d_ack), 32'd0);
    chk("to_err_end", 0, 32'(bus_err), 32'd0);

    // Ready on the last watchdog cycle is a normal completion; IDLE regrants at once
    step();
    chk("bnd_grant", 0, 32'(mem_req), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("bnd_wait_ack", k, 32'(d_ack), 32'd0);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    chk("bnd_ack", 0, 32'(d_ack), 32'd1);
    chk("bnd_err", 0, 32'(bus_err), 32'd0);
    chk("bnd_rdata", 0, d_rdata, 32'h0BADF00D);
    mem_ready = 1'b0;
    step();

    // Reset during a data grant: no ack, bus released, IF wins the next tie
    if_req = 1'b0; d_req = 1'b1;
    step();
    chk("rst_grant", 0, 32'(mem_req), 32'd1);
    chk("rst_grant_addr", 0, mem_addr, 32'h300);
    reset = 1'b0; if_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h77777777;
    step();
    chk("rst_mreq", 0, 32'(mem_req), 32'd0);
    chk("rst_dack", 0, 32'(d_ack), 32'd0);
    chk("rst_drdata", 0, d_rdata, 32'h0);
    reset = 1'b1; mem_ready = 1'b0;
    step();
    chk("rst_tie_req", 0, 32'(mem_req), 32'd1);
    chk("rst_tie_addr", 0, mem_addr, 32'h100);
    mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    step();
    chk("rst_if_ack", 0, 32'(if_ack), 32'd1);
    chk("rst_d_ack", 0, 32'(d_ack), 32'd0);
    chk("rst_if_rdata", 0, if_rdata, 32'hA5A5A5A5);
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    step();
    chk("final_ack", 0, 32'(if_ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
